// File: rtl/striping_pkg.sv
// Shared definitions for the two-lane byte striper.
// Holds the default byte width, the layout of a FIFO pair entry
// ({b0, b1, v1}, v1 in the LSB), the pair-select states and the
// output phase encoding.
package striping_pkg;

  localparam int DEF_DATA_W = 8;

  // Pair entry layout: [b0 | b1 | v1]
  localparam int V1_BIT = 0;
  localparam int B1_LSB = 1;

  function automatic int pair_w(input int dw);
    return 2 * dw + 1;
  endfunction

  function automatic int b0_lsb(input int dw);
    return dw + 1;
  endfunction

  typedef enum logic {
    SEL_B0 = 1'b0,
    SEL_B1 = 1'b1
  } sel_t;

  typedef enum logic {
    PH_WAIT   = 1'b0,
    PH_UPDATE = 1'b1
  } phase_t;

endpackage

// File: rtl/striping_if.sv
// Byte-stream input and two-lane output bundle of the striper.
//   data_in/valid_in/ready_in : input byte handshake
//   out_enable                : downstream may take lane data
//   lane_0/valid_0            : lane 0 byte and valid
//   lane_1/valid_1            : lane 1 byte and valid
//   error_out                 : sticky dropped-byte flag
// slave is the striper side, master is the driver/observer side.
interface striping_if
  import striping_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_in;
  logic              out_enable;
  logic [DATA_W-1:0] lane_0;
  logic              valid_0;
  logic [DATA_W-1:0] lane_1;
  logic              valid_1;
  logic              error_out;

  modport slave (
    input  data_in, valid_in, out_enable,
    output ready_in, lane_0, valid_0, lane_1, valid_1, error_out
  );

  modport master (
    output data_in, valid_in, out_enable,
    input  ready_in, lane_0, valid_0, lane_1, valid_1, error_out
  );
endinterface

// File: rtl/striping_pair_fifo.sv
// Small registered FIFO for byte pairs.
//   clk, rst_n           : clock, async active-low reset
//   push, push_data      : write one entry (ignored when full)
//   pop, pop_data        : read head entry (pop_data is the current head)
//   full, empty          : occupancy flags, registered
// An entry pushed at one edge becomes visible at the following edge.
module striping_pair_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/striping.sv
// Transmit-side byte striper for the two-lane PHY path.
//   clk_2f : single clock
//   reset  : async active-low reset
//   bus    : striping_if.slave (input handshake, lane outputs, error flag)
// Consecutive bytes are paired (first -> lane 0, second -> lane 1), queued
// in a pair FIFO and presented on both lanes every second clk_2f cycle.
// A lone trailing byte is flushed on lane 0 after FLUSH_CYCLES idle cycles.
//
// state   | meaning
// SEL_B0  | no byte held; next accepted byte becomes b0
// SEL_B1  | b0 held; next byte completes the pair, or timeout flushes b0
module striping
  import striping_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic       clk_2f,
  input  logic       reset,
  striping_if.slave  bus
);
  localparam int PAIR_W = pair_w(DATA_W);
  localparam int B0_LSB = b0_lsb(DATA_W);
  localparam int TMR_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(FLUSH_CYCLES - 1);

  sel_t              sel_q, sel_d;
  phase_t            phase_q;
  logic [DATA_W-1:0] hold_q;
  logic [TMR_W-1:0]  idle_tmr_q;
  logic              accept;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PAIR_W-1:0] push_data;
  logic [PAIR_W-1:0] pop_data;
  logic [DATA_W-1:0] lane_0_q, lane_1_q;
  logic              valid_0_q, valid_1_q, error_q;

  assign bus.ready_in  = (sel_q == SEL_B0) || !fifo_full;
  assign accept        = bus.valid_in && bus.ready_in;
  assign pop           = (phase_q == PH_UPDATE) && bus.out_enable && !fifo_empty;
  assign bus.lane_0    = lane_0_q;
  assign bus.lane_1    = lane_1_q;
  assign bus.valid_0   = valid_0_q;
  assign bus.valid_1   = valid_1_q;
  assign bus.error_out = error_q;

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) sel_q <= SEL_B0;
    else        sel_q <= sel_d;
  end

  // Flush waits (timer stays at zero) while the FIFO is full, so the held
  // byte is never lost.
  always_comb begin
    sel_d     = sel_q;
    push      = 1'b0;
    push_data = '0;
    unique case (sel_q)
      SEL_B0: begin
        if (accept) sel_d = SEL_B1;
      end
      SEL_B1: begin
        if (accept) begin
          push      = 1'b1;
          push_data = {hold_q, bus.data_in, 1'b1};
          sel_d     = SEL_B0;
        end else if (idle_tmr_q == '0 && !fifo_full) begin
          push      = 1'b1;
          push_data = {hold_q, {DATA_W{1'b0}}, 1'b0};
          sel_d     = SEL_B0;
        end
      end
      default: sel_d = SEL_B0;
    endcase
  end

  // Idle timer counts down from FLUSH_CYCLES-1; reaching zero on an idle
  // cycle marks the FLUSH_CYCLES-th idle cycle.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      hold_q     <= '0;
      idle_tmr_q <= '0;
    end else if (accept && sel_q == SEL_B0) begin
      hold_q     <= bus.data_in;
      idle_tmr_q <= TMR_LOAD;
    end else if (sel_q == SEL_B1 && !accept && idle_tmr_q != '0) begin
      idle_tmr_q <= idle_tmr_q - 1'b1;
    end
  end

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) phase_q <= PH_WAIT;
    else        phase_q <= (phase_q == PH_UPDATE) ? PH_WAIT : PH_UPDATE;
  end

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      lane_0_q  <= '0;
      lane_1_q  <= '0;
      valid_0_q <= 1'b0;
      valid_1_q <= 1'b0;
    end else if (phase_q == PH_UPDATE) begin
      if (pop) begin
        lane_0_q  <= pop_data[B0_LSB +: DATA_W];
        lane_1_q  <= pop_data[B1_LSB +: DATA_W];
        valid_0_q <= 1'b1;
        valid_1_q <= pop_data[V1_BIT];
      end else begin
        valid_0_q <= 1'b0;
        valid_1_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset)                             error_q <= 1'b0;
    else if (bus.valid_in && !bus.ready_in) error_q <= 1'b1;
  end

  striping_pair_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_pair_fifo (
    .clk       (clk_2f),
    .rst_n     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_striping.sv
// Self-checking bench for striping: a queue-based model checked every
// cycle, plus literal expectations per scenario.
module tb_striping;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int FLUSH = 4;

  typedef struct packed {
    logic [7:0] b0;
    logic [7:0] b1;
    logic       v1;
  } beat_t;

  logic clk_2f = 1'b0;
  logic reset  = 1'b0;
  int   n_checks = 0;
  int   n_err    = 0;

  striping_if #(.DATA_W(DW)) bus();

  striping #(
    .DATA_W       (DW),
    .FIFO_DEPTH   (DEPTH),
    .FLUSH_CYCLES (FLUSH)
  ) dut (
    .clk_2f (clk_2f),
    .reset  (reset),
    .bus    (bus.slave)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  beat_t      mq[$];
  beat_t      m_new;
  beat_t      m_out;
  bit         m_held  = 0;
  logic [7:0] m_hold  = 0;
  int         m_idle  = 0;
  bit         m_phase = 0;
  logic [7:0] m_l0    = 0;
  logic [7:0] m_l1    = 0;
  bit         m_v0    = 0;
  bit         m_v1    = 0;
  bit         m_err   = 0;
  bit         m_rdy;
  bit         m_push;
  int         m_sz;

  always @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_held = 0; m_hold = 0; m_idle = 0; m_phase = 0;
      m_l0 = 0; m_l1 = 0; m_v0 = 0; m_v1 = 0; m_err = 0;
    end else begin
      m_sz   = mq.size();
      m_rdy  = !m_held || (m_sz < DEPTH);
      m_push = 0;
      if (bus.valid_in && !m_rdy) m_err = 1;
      if (bus.valid_in && m_rdy) begin
        if (!m_held) begin
          m_held = 1; m_hold = bus.data_in; m_idle = 0;
        end else begin
          m_new = '{b0: m_hold, b1: bus.data_in, v1: 1'b1};
          m_push = 1; m_held = 0;
        end
      end else if (m_held) begin
        if (m_idle < FLUSH) m_idle++;
        if (m_idle >= FLUSH && m_sz < DEPTH) begin
          m_new = '{b0: m_hold, b1: 8'h00, v1: 1'b0};
          m_push = 1; m_held = 0;
        end
      end
      if (m_phase) begin
        if (bus.out_enable && m_sz > 0) begin
          m_out = mq.pop_front();
          m_l0 = m_out.b0; m_l1 = m_out.b1; m_v0 = 1; m_v1 = m_out.v1;
        end else begin
          m_v0 = 0; m_v1 = 0;
        end
      end
      if (m_push) mq.push_back(m_new);
      m_phase = !m_phase;
    end
  end

  always @(negedge clk_2f) begin
    if (reset) begin
      chk("model_lane_0",    bus.lane_0,    m_l0);
      chk("model_lane_1",    bus.lane_1,    m_l1);
      chk("model_valid_0",   bus.valid_0,   m_v0);
      chk("model_valid_1",   bus.valid_1,   m_v1);
      chk("model_error_out", bus.error_out, m_err);
      chk("model_ready_in",  bus.ready_in,  (!m_held || mq.size() < DEPTH));
    end
  end

  // ---------------- beat recorder ----------------
  // Every lane word is held two cycles; the first cycle of each pair of a
  // valid run starts a new word.
  beat_t beats[$];
  int    run  = 0;
  int    vcyc = 0;

  always @(negedge clk_2f) begin
    if (reset && bus.valid_0) begin
      run++; vcyc++;
      if (run % 2 == 1) beats.push_back('{b0: bus.lane_0, b1: bus.lane_1, v1: bus.valid_1});
    end else begin
      run = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [7:0] d);
    @(posedge clk_2f); #2;
    bus.valid_in = v;
    bus.data_in  = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  task automatic chk_beat(input string name, input int idx, input logic [7:0] b0,
                          input logic [7:0] b1, input logic v1);
    beat_t e;
    e = '{b0: b0, b1: b1, v1: v1};
    if (idx < beats.size()) begin
      chk(name, 32'(beats[idx]), 32'(e));
    end else begin
      n_checks++; n_err++;
      $display("FAIL %s missing beat %0d, expected=%0h", name, idx, 32'(e));
    end
  endtask

  task automatic clear_rec();
    beats.delete();
    vcyc = 0;
  endtask

  logic [7:0] sent[$];
  logic [7:0] rx[$];

  initial begin
    bus.valid_in   = 1'b0;
    bus.data_in    = 8'h00;
    bus.out_enable = 1'b1;
    #1;
    chk("rst_lane_0",  bus.lane_0,    0);
    chk("rst_valid_0", bus.valid_0,   0);
    chk("rst_valid_1", bus.valid_1,   0);
    chk("rst_error",   bus.error_out, 0);
    chk("rst_ready",   bus.ready_in,  1);
    #21 reset = 1'b1;

    // Even stream
    clear_rec();
    drive(1, 8'hA1); drive(1, 8'hB2); drive(1, 8'hC3); drive(1, 8'hD4);
    idle(10);
    chk("even_count", beats.size(), 2);
    chk_beat("even_pair0", 0, 8'hA1, 8'hB2, 1'b1);
    chk_beat("even_pair1", 1, 8'hC3, 8'hD4, 1'b1);
    chk("even_valid_cycles", vcyc, 4);

    // Odd byte flush
    clear_rec();
    drive(1, 8'h55);
    idle(12);
    chk("odd_count", beats.size(), 1);
    chk_beat("odd_flush", 0, 8'h55, 8'h00, 1'b0);
    chk("odd_valid_cycles", vcyc, 2);

    // Second byte lands on the edge the timeout would expire
    clear_rec();
    drive(1, 8'h66);
    idle(3);
    drive(1, 8'h77);
    idle(12);
    chk("late_count", beats.size(), 1);
    chk_beat("late_pair", 0, 8'h66, 8'h77, 1'b1);

    // Loopback: random even-length bursts, reassembled from the lanes
    clear_rec();
    sent.delete();
    begin
      int remaining = 64;
      while (remaining > 0) begin
        int len = 2 * $urandom_range(1, 4);
        if (len > remaining) len = remaining;
        for (int i = 0; i < len; i++) begin
          logic [7:0] b = 8'($urandom_range(0, 255));
          sent.push_back(b);
          drive(1, b);
        end
        remaining -= len;
        idle($urandom_range(0, 3));
      end
    end
    idle(12);
    rx.delete();
    foreach (beats[i]) begin
      rx.push_back(beats[i].b0);
      if (beats[i].v1) rx.push_back(beats[i].b1);
    end
    chk("loop_len", rx.size(), sent.size());
    for (int i = 0; i < sent.size() && i < rx.size(); i++) chk("loop_byte", rx[i], sent[i]);

    // Backpressure
    clear_rec();
    bus.out_enable = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      drive(1, 8'(k));
      @(negedge clk_2f);
      chk("bp_ready", bus.ready_in, (k <= 9));
    end
    drive(0, 8'h00);
    @(negedge clk_2f);
    chk("bp_error", bus.error_out, 1);
    bus.out_enable = 1'b1;
    idle(20);
    chk("bp_count", beats.size(), 5);
    chk_beat("bp_pair0", 0, 8'h01, 8'h02, 1'b1);
    chk_beat("bp_pair1", 1, 8'h03, 8'h04, 1'b1);
    chk_beat("bp_pair2", 2, 8'h05, 8'h06, 1'b1);
    chk_beat("bp_pair3", 3, 8'h07, 8'h08, 1'b1);
    chk_beat("bp_flush", 4, 8'h09, 8'h00, 1'b0);
    chk("bp_ready_back", bus.ready_in, 1);

    // Reset mid-stream
    bus.out_enable = 1'b0;
    for (int k = 1; k <= 6; k++) drive(1, 8'(8'h10 + k));
    drive(0, 8'h00);
    bus.out_enable = 1'b1;
    idle(3);
    @(negedge clk_2f);
    chk("pre_rst_valid_0", bus.valid_0, 1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_lane_0",  bus.lane_0,    0);
    chk("mid_rst_lane_1",  bus.lane_1,    0);
    chk("mid_rst_valid_0", bus.valid_0,   0);
    chk("mid_rst_valid_1", bus.valid_1,   0);
    chk("mid_rst_error",   bus.error_out, 0);
    chk("mid_rst_ready",   bus.ready_in,  1);
    repeat (3) @(posedge clk_2f);
    @(negedge clk_2f);
    #2 reset = 1'b1;
    clear_rec();
    idle(8);
    chk("post_rst_beats", beats.size(), 0);
    chk("post_rst_ready", bus.ready_in, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/striping.md
Name: striping

Overview:
- Transmit-side byte striper for the two-lane PHY path; runs entirely on clk_2f.
- Accepts one byte per cycle and pairs consecutive bytes: first byte goes to lane 0, second to lane 1.
- Each pair is buffered in a small FIFO and presented on both lanes together. Lanes update only every second clk_2f cycle, so lane data runs at clk_f rate.
- A lone trailing byte is flushed after a timeout, on lane 0 only.

Parameters:
DATA_W, 8, byte width of data_in and of each lane.
FIFO_DEPTH, 4, pair FIFO depth in entries; power of 2, at least 2.
FLUSH_CYCLES, 4, number of consecutive idle cycles with a half-pair held before that lone byte is flushed; at least 1.

Ports:
clk_2f  in  1  single clock
reset  in  1  asynchronous, active-low reset
data_in  in  DATA_W  input byte
valid_in  in  1  data_in valid
ready_in  out  1  byte accepted this cycle when valid_in && ready_in
out_enable  in  1  downstream lanes may take data; when low, no FIFO pop occurs
lane_0  out  DATA_W  lane 0 byte
valid_0  out  1  lane 0 valid
lane_1  out  DATA_W  lane 1 byte
valid_1  out  1  lane 1 valid
error_out  out  1  sticky; set when valid_in=1 && ready_in=0

Behaviour:
- Reset (async, reset=0), effective immediately:
  - lane_0, lane_1, valid_0, valid_1, error_out all 0.
  - FIFO empty; sel=0; phase=0; idle counter=0.
  - ready_in=1 (combinational).
- Acceptance: ready_in = (sel==0) || !fifo_full.
- Byte accepted with sel=0: hold <= data_in; sel <= 1; idle counter <= 0.
- Byte accepted with sel=1:
  - Push {hold, data_in, v1=1} into the FIFO; sel <= 0.
- Flush:
  - Condition: sel=1, no byte accepted, and idle counter reaches FLUSH_CYCLES.
  - Action: push {hold, 0, v1=0}; sel <= 0.
  - If the FIFO is full at that point, the counter saturates and the flush waits until space frees. The byte is never dropped.
  - Any accepted byte resets the idle counter.
- Phase: toggles every cycle after reset release. The first edge after release sees phase=0.
- Pop and output update, only at edges where phase==1:
  - If out_enable && !fifo_empty: pop the FIFO; lane_0 <= entry.b0; lane_1 <= entry.b1; valid_0 <= 1; valid_1 <= entry.v1.
  - Otherwise: valid_0 <= 0; valid_1 <= 0; lane data holds its last value.
  - Outputs are therefore stable for exactly 2 clk_2f cycles.
- FIFO timing:
  - Registered FIFO; a pair pushed at edge k is poppable at the earliest at edge k+1.
  - Latency from acceptance of the second byte to valid lanes is 1–2 edges, depending on phase.
  - Simultaneous push and pop: occupancy is unchanged. Push to a full FIFO cannot occur (prevented by ready_in and the flush wait).
  - Pointers wrap modulo FIFO_DEPTH.
- error_out sets on any cycle with valid_in && !ready_in; that byte is dropped. It is cleared only by reset.
- Ordering: byte order is preserved; b0 always precedes b1.
- Continuous input of one byte per cycle with out_enable=1 never deasserts ready_in.

Decomposition:
- Shared package:
  - DATA_W default.
  - Pair entry width 2*DATA_W+1 and field offsets (b0, b1, v1).
  - Phase encoding constants.
- One sub-module: striping_pair_fifo. Parameterised depth/width, synchronous push/pop, full/empty flags, async active-low reset.

Test Plan:
- Reset mid-stream:
  - Stimulus: drive reset=0 while pairs are queued and lanes are valid.
  - Required: outputs go 0 in the same cycle with no clock edge; after release, the FIFO is empty and ready_in=1.
- Even stream:
  - Stimulus: 0xA1, 0xB2, 0xC3, 0xD4 on consecutive cycles, out_enable=1.
  - Required: lane_0/lane_1 = A1/B2, then C3/D4; valid_0=valid_1=1; each pair held 2 cycles; then valids drop to 0.
- Odd byte flush:
  - Stimulus: a single 0x55, then idle, FLUSH_CYCLES=4.
  - Required: after 4 idle cycles the pair is pushed; lane_0=0x55, valid_0=1, valid_1=0, lane_1=0x00.
- Backpressure:
  - Stimulus: out_enable=0, FIFO_DEPTH=4, valid_in held for 10 bytes 0x01–0x0A.
  - Required: bytes 1–9 accepted; ready_in=0 at byte 10 and error_out=1.
  - Then raise out_enable: pairs 01/02 … 07/08 are emitted in order, ready_in returns to 1, and 0x09 is flushed alone later.
- Loopback:
  - Stimulus: 64 random bytes (even-length bursts) through striping, then unstriping on the same clk_2f.
  - Required: the unstriping data_out sequence equals the input sequence exactly.
- Flush versus late byte:
  - Stimulus: a second byte arrives on the cycle the idle counter would reach FLUSH_CYCLES.
  - Required: a normal pair with v1=1 is pushed, and no flush entry is created.
